// File: rtl/btb_predictor_pkg.sv
// rtl/btb_predictor_pkg.sv - shared defaults, update record and counter helper for btb_predictor
// Purpose: default geometry of the fetch-stage predictor, the BtbUpdate record
//          carried from execute, and the 2-bit saturating counter step.
// Ports:   none (package).
package btb_predictor_pkg;

   localparam int fetchWidth = 4;
   localparam int opaqueBits = 10;
   localparam int btbEntries = 16;
   localparam int bhtEntries = 64;
   localparam int histBits   = 6;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_WEAK_NT = 2'b01;

   // Resolution record at the default widths; modules keep flat ports so
   // their parameters can differ from these defaults.
   typedef struct packed {
      logic [31:0]           pc;
      logic [31:0]           target;
      logic                  taken;
      logic                  is_jump;
      logic                  hit;
      logic [opaqueBits-1:0] entry;
      logic [histBits-1:0]   hist;
   } BtbUpdate;

   function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
      if (taken) begin
         return (ctr == 2'b11) ? ctr : ctr + 2'b01;
      end
      return (ctr == 2'b00) ? ctr : ctr - 2'b01;
   endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// rtl/btb_predictor_if.sv - lookup, response and training bus of btb_predictor
// Purpose: groups the fetch lookup request/response and the execute-stage
//          resolution port into one bundle.
// Ports:   req_valid/req_addr          lookup request
//          resp_*                      prediction, valid one cycle after req_valid
//          upd_*                       resolved control-flow instruction
//          invalidate                  clear every BTB entry
// Modports: master = fetch/execute side, slave = predictor.
interface btb_predictor_if #(
   parameter int FETCH_WIDTH = 4,
   parameter int OPAQUE_BITS = 10,
   parameter int HIST_BITS   = 6
);
   localparam int SLOT_BITS = $clog2(FETCH_WIDTH);

   logic                   req_valid;
   logic [31:0]            req_addr;

   logic                   resp_valid;
   logic                   resp_taken;
   logic [FETCH_WIDTH-1:0] resp_mask;
   logic [SLOT_BITS-1:0]   resp_bridx;
   logic [31:0]            resp_target;
   logic [OPAQUE_BITS-1:0] resp_entry;
   logic [HIST_BITS-1:0]   resp_hist;
   logic [1:0]             resp_ctr;

   logic                   upd_valid;
   logic [31:0]            upd_pc;
   logic [31:0]            upd_target;
   logic                   upd_taken;
   logic                   upd_is_jump;
   logic                   upd_hit;
   logic [OPAQUE_BITS-1:0] upd_entry;
   logic [HIST_BITS-1:0]   upd_hist;

   logic                   invalidate;

   modport master (
      output req_valid, req_addr,
      output upd_valid, upd_pc, upd_target, upd_taken, upd_is_jump,
      output upd_hit, upd_entry, upd_hist, invalidate,
      input  resp_valid, resp_taken, resp_mask, resp_bridx,
      input  resp_target, resp_entry, resp_hist, resp_ctr
   );

   modport slave (
      input  req_valid, req_addr,
      input  upd_valid, upd_pc, upd_target, upd_taken, upd_is_jump,
      input  upd_hit, upd_entry, upd_hist, invalidate,
      output resp_valid, resp_taken, resp_mask, resp_bridx,
      output resp_target, resp_entry, resp_hist, resp_ctr
   );

endinterface

// File: rtl/btb_predictor_bht_table.sv
// rtl/btb_predictor_bht_table.sv - gshare counter array and global history
// Purpose: combinational counter read for the lookup address hashed with the
//          current history; saturating counter and history update on every
//          resolved conditional branch. Only instantiated when BTB_BHT_EN is set.
// Ports:   clk, reset                  clock, synchronous active-high reset
//          lkp_addr -> lkp_ctr/lkp_hist counter and history used by a lookup
//          upd_valid/upd_pc/upd_hist/upd_taken/upd_is_jump  training input
module btb_predictor_bht_table
   import btb_predictor_pkg::*;
#(
   parameter int BHT_ENTRIES = bhtEntries,
   parameter int HIST_BITS   = histBits
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          lkp_addr,
   output ctr_t                 lkp_ctr,
   output logic [HIST_BITS-1:0] lkp_hist,
   input  logic                 upd_valid,
   input  logic [31:0]          upd_pc,
   input  logic [HIST_BITS-1:0] upd_hist,
   input  logic                 upd_taken,
   input  logic                 upd_is_jump
);
   localparam int IDX_BITS = $clog2(BHT_ENTRIES);

   ctr_t                 ctr_q [BHT_ENTRIES];
   logic [HIST_BITS-1:0] hist_q;
   logic [IDX_BITS-1:0]  lkp_idx;
   logic [IDX_BITS-1:0]  upd_idx;

   // gshare: word-aligned PC bits folded with zero-extended history.
   assign lkp_idx  = lkp_addr[IDX_BITS+1:2] ^ IDX_BITS'(hist_q);
   assign upd_idx  = upd_pc[IDX_BITS+1:2] ^ IDX_BITS'(upd_hist);
   assign lkp_ctr  = ctr_q[lkp_idx];
   assign lkp_hist = hist_q;

   logic unused_bits;
   assign unused_bits = ^{lkp_addr, upd_pc};

   // Unconditional jumps carry no direction information and leave both the
   // counters and the history alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            ctr_q[i] <= CTR_WEAK_NT;
         end
         hist_q <= '0;
      end else if (upd_valid && !upd_is_jump) begin
         ctr_q[upd_idx] <= ctr_next(ctr_q[upd_idx], upd_taken);
         hist_q         <= {hist_q[HIST_BITS-2:0], upd_taken};
      end
   end

endmodule

// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - fetch-stage branch target buffer with optional gshare direction
// Purpose: fully associative BTB looked up per fetch block, answered one cycle
//          later from table state as of the request cycle; trained from execute,
//          FIFO replacement, flushed by invalidate.
// Macro:   BTB_BHT_EN - when defined, conditional direction comes from the gshare
//          counters; when undefined every hit predicts taken, resp_hist=0,
//          resp_ctr=2'b11.
// Ports:   clk, reset                  clock, synchronous active-high reset
//          bus (btb_predictor_if.slave) lookup request/response, training, invalidate
module btb_predictor
   import btb_predictor_pkg::*;
#(
   parameter int FETCH_WIDTH = fetchWidth,
   parameter int ENTRIES     = btbEntries,
   parameter int BHT_ENTRIES = bhtEntries,
   parameter int HIST_BITS   = histBits,
   parameter int OPAQUE_BITS = opaqueBits
) (
   input logic            clk,
   input logic            reset,
   btb_predictor_if.slave bus
);
   localparam int SLOT_BITS = $clog2(FETCH_WIDTH);
   localparam int BOFF      = SLOT_BITS + 2;
   localparam int TAG_BITS  = 32 - BOFF;
   localparam int IDX_BITS  = $clog2(ENTRIES);

   logic [ENTRIES-1:0]   valid_q;
   logic [ENTRIES-1:0]   jump_q;
   logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
   logic [SLOT_BITS-1:0] bridx_q  [ENTRIES];
   logic [31:0]          target_q [ENTRIES];
   logic [IDX_BITS-1:0]  ptr_q;

   logic [TAG_BITS-1:0]    req_tag;
   logic [SLOT_BITS-1:0]   req_slot;
   logic [TAG_BITS-1:0]    upd_tag;
   logic [SLOT_BITS-1:0]   upd_slot;
   logic [IDX_BITS-1:0]    upd_idx;

   logic                   lk_hit;
   logic [IDX_BITS-1:0]    lk_idx;
   logic                   lk_taken;
   logic [SLOT_BITS-1:0]   lk_last;
   logic [FETCH_WIDTH-1:0] lk_mask;
   logic [SLOT_BITS-1:0]   lk_bridx;
   logic [31:0]            lk_target;
   ctr_t                   lk_ctr;
   logic [HIST_BITS-1:0]   lk_hist;

   assign req_tag  = bus.req_addr[31:BOFF];
   assign req_slot = bus.req_addr[BOFF-1:2];
   assign upd_tag  = bus.upd_pc[31:BOFF];
   assign upd_slot = bus.upd_pc[BOFF-1:2];
   assign upd_idx  = bus.upd_entry[IDX_BITS-1:0];

`ifdef BTB_BHT_EN
   btb_predictor_bht_table #(
      .BHT_ENTRIES (BHT_ENTRIES),
      .HIST_BITS   (HIST_BITS)
   ) u_bht (
      .clk         (clk),
      .reset       (reset),
      .lkp_addr    (bus.req_addr),
      .lkp_ctr     (lk_ctr),
      .lkp_hist    (lk_hist),
      .upd_valid   (bus.upd_valid),
      .upd_pc      (bus.upd_pc),
      .upd_hist    (bus.upd_hist),
      .upd_taken   (bus.upd_taken),
      .upd_is_jump (bus.upd_is_jump)
   );

   logic unused_bits;
   assign unused_bits = ^{bus.req_addr[1:0], bus.upd_pc[1:0], bus.upd_entry};
`else
   // A strongly-taken counter makes every hit predict taken.
   assign lk_ctr  = 2'b11;
   assign lk_hist = '0;

   logic unused_bits;
   assign unused_bits = ^{bus.req_addr[1:0], bus.upd_pc[1:0], bus.upd_entry, bus.upd_hist};
`endif

   // Scanning downward lets the lowest matching index win should two entries
   // ever match. An entry only matches if its branch lies at or after the
   // slot the fetch block is entered at.
   always_comb begin
      lk_hit = 1'b0;
      lk_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (valid_q[i] && (tag_q[i] == req_tag) && (bridx_q[i] >= req_slot)) begin
            lk_hit = 1'b1;
            lk_idx = IDX_BITS'(i);
         end
      end
      lk_taken  = lk_hit && (jump_q[lk_idx] || lk_ctr[1]);
      lk_last   = lk_taken ? bridx_q[lk_idx] : SLOT_BITS'(FETCH_WIDTH - 1);
      lk_mask   = '0;
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         lk_mask[k] = (SLOT_BITS'(k) >= req_slot) && (SLOT_BITS'(k) <= lk_last);
      end
      lk_bridx  = lk_hit ? bridx_q[lk_idx] : SLOT_BITS'(FETCH_WIDTH - 1);
      lk_target = lk_hit ? target_q[lk_idx] : '0;
   end

   // Response fields only move on a request so fetch can keep using them.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.resp_valid  <= 1'b0;
         bus.resp_taken  <= 1'b0;
         bus.resp_mask   <= '0;
         bus.resp_bridx  <= '0;
         bus.resp_target <= '0;
         bus.resp_entry  <= '0;
         bus.resp_hist   <= '0;
         bus.resp_ctr    <= '0;
      end else begin
         bus.resp_valid <= bus.req_valid;
         if (bus.req_valid) begin
            bus.resp_taken  <= lk_taken;
            bus.resp_mask   <= lk_mask;
            bus.resp_bridx  <= lk_bridx;
            bus.resp_target <= lk_target;
            bus.resp_entry  <= lk_hit ? OPAQUE_BITS'(lk_idx) : '0;
            bus.resp_hist   <= lk_hist;
            bus.resp_ctr    <= lk_ctr;
         end
      end
   end

   // Taken branches either refresh the entry they hit or allocate at the
   // FIFO pointer. The invalidate clear comes last so it overrides any valid
   // bit set in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         ptr_q   <= '0;
      end else begin
         if (bus.upd_valid && bus.upd_taken) begin
            if (bus.upd_hit) begin
               target_q[upd_idx] <= bus.upd_target;
               bridx_q[upd_idx]  <= upd_slot;
               jump_q[upd_idx]   <= bus.upd_is_jump;
            end else begin
               tag_q[ptr_q]    <= upd_tag;
               target_q[ptr_q] <= bus.upd_target;
               bridx_q[ptr_q]  <= upd_slot;
               jump_q[ptr_q]   <= bus.upd_is_jump;
               valid_q[ptr_q]  <= 1'b1;
               ptr_q           <= ptr_q + 1'b1;
            end
         end
         if (bus.invalidate) begin
            valid_q <= '0;
         end
      end
   end

endmodule
